// File: rtl/lcd_morph_view_if.sv
// lcd_morph_view_if: scan position, mode, ROM port and composited pixel bundle.
interface lcd_morph_view_if #(
  parameter int PW = 24,
  parameter int AW = 16
);
  logic [10:0]   pixel_xpos;
  logic [10:0]   pixel_ypos;
  logic [1:0]    mode;
  logic [AW-1:0] rom_addr;
  logic [PW-1:0] rom_rd_data;
  logic [PW-1:0] pixel_data;
  logic [1:0]    mode_active;
  logic          frame_done;
  modport master (
    output pixel_xpos, pixel_ypos, mode, rom_rd_data,
    input  rom_addr, pixel_data, mode_active, frame_done
  );
  modport slave (
    input  pixel_xpos, pixel_ypos, mode, rom_rd_data,
    output rom_addr, pixel_data, mode_active, frame_done
  );
endinterface

// File: rtl/lcd_morph_view.sv
// lcd_morph_view: side-by-side source / 3x3 morphology compositor.
// Define MORPH_BORDER_REPLICATE_EN to show original border pixels instead of BG.
module lcd_morph_view #(
  parameter int CH_W = 8,
  parameter int PIC_W = 250,
  parameter int PIC_H = 250,
  parameter int X0 = 2,
  parameter int Y0 = 0,
  parameter int X_DIV = 300,
  parameter int AW = 16,
  parameter logic [3*CH_W-1:0] BG = '1
) (
  input logic lcd_pclk,
  input logic rst,
  lcd_morph_view_if.slave bus
);
  localparam int PW = 3 * CH_W;
  localparam int CW = $clog2(PIC_W);
  typedef logic [PW-1:0] px_t;
  px_t buf1 [PIC_W];
  px_t buf2 [PIC_W];
  px_t res_ram [PIC_W];
  px_t win [9];
  px_t res, wv;
  logic [CH_W-1:0] mn, mx;
  logic frame_ok, done_d;
  logic fetch, left, shift, wr, right, border;
  int lx, ly, rx;
  assign lx = int'(bus.pixel_xpos) - X0;
  assign ly = int'(bus.pixel_ypos) - Y0;
  assign rx = lx - X_DIV;
  assign fetch = ly >= 0 && ly < PIC_H && lx >= -1 && lx < PIC_W - 1;
  assign left = ly >= 0 && ly < PIC_H && lx >= 0 && lx < PIC_W;
  assign shift = ly >= 0 && ly <= PIC_H && lx >= 0 && lx <= PIC_W;
  assign wr = ly >= 1 && ly <= PIC_H && lx >= 2 && lx <= PIC_W + 1;
  assign right = ly >= 1 && ly <= PIC_H && rx >= 0 && rx < PIC_W;
  // result written for column lx-2 of row ly-1
  assign border = ly == 1 || ly == PIC_H || lx == 2 || lx == PIC_W + 1;
  assign bus.rom_addr = fetch && !rst ? AW'(ly * PIC_W + lx + 1) : '0;
  always_comb begin
    res = '0;
    mn = '1;
    mx = '0;
    for (int k = 0; k < 3; k++) begin
      mn = '1;
      mx = '0;
      for (int j = 0; j < 9; j++) begin
        mn = win[j][k*CH_W +: CH_W] < mn ? win[j][k*CH_W +: CH_W] : mn;
        mx = win[j][k*CH_W +: CH_W] > mx ? win[j][k*CH_W +: CH_W] : mx;
      end
      res[k*CH_W +: CH_W] = bus.mode_active == 2'd1 ? mn : bus.mode_active == 2'd2 ? mx : mx - mn;
    end
    res = bus.mode_active == 2'd0 ? win[4] : res;
  end
`ifdef MORPH_BORDER_REPLICATE_EN
  assign wv = border ? win[4] : res;
`else
  assign wv = border ? BG : res;
`endif
  // win[0..2] newest column (top, centre, bottom); win[4] is the centre tap
  always_ff @(posedge lcd_pclk) begin
    if (left) begin
      buf2[CW'(lx)] <= buf1[CW'(lx)];
      buf1[CW'(lx)] <= bus.rom_rd_data;
    end
    if (shift)
      win <= '{buf2[CW'(lx)], buf1[CW'(lx)], bus.rom_rd_data, win[0], win[1], win[2], win[3], win[4], win[5]};
    if (wr)
      res_ram[CW'(lx - 2)] <= wv;
    if (rst) begin
      bus.pixel_data <= BG;
      bus.mode_active <= '0;
      bus.frame_done <= 1'b0;
      frame_ok <= 1'b0;
      done_d <= 1'b0;
    end else begin
      if (bus.pixel_xpos == '0 && bus.pixel_ypos == '0) begin
        bus.mode_active <= bus.mode;
        frame_ok <= 1'b1;
      end
      bus.pixel_data <= !frame_ok ? BG : left ? bus.rom_rd_data : right ? res_ram[CW'(rx)] : BG;
      done_d <= frame_ok && right && ly == PIC_H && rx == PIC_W - 1;
      bus.frame_done <= done_d;
    end
  end
endmodule
